i2c_target_regs: RTL
====================

// Module: i2c_target_regs
// PURPOSE
//  Parametrised I2C target (slave) with an addressable register file. It replaces the
//  fixed-pattern, free-running peripheral with a full bit-level protocol engine:
//  START/STOP/repeated-START detection, address match, ACK/NACK, pointer-based
//  multi-byte writes and reads with auto-increment. Sits between the chip pads
//  (open-drain SDA) and fabric logic that consumes or updates the registers.
// PARAMETERS
//  TARGET_ADDR  7'h2A   7-bit bus address matched after START
//  NUM_REGS     4       register count, 1..16; pointer width PTR_W = max(1,$clog2(NUM_REGS))
//  RESET_VAL    8'h00   value loaded into every register on reset
//  SYNC_STAGES  2       flops in the SCL/SDA input synchroniser, >= 2
// PORTS
//  clk          in   1               system clock, >= 8x SCL frequency
//  reset        in   1               synchronous, active-high
//  scl_in       in   1               SCL pad input, asynchronous
//  sda_in       in   1               SDA pad input, asynchronous
//  sda_oe       out  1               1 = pull SDA low; 0 = release (pad is open-drain)
//  host_wr_en   in   1               fabric write strobe
//  host_wr_idx  in   PTR_W           fabric write index
//  host_wr_data in   8               fabric write data
//  regs_flat    out  8*NUM_REGS      register file, reg i at [8*i+7:8*i]
//  i2c_wr_pulse out  1               1-cycle pulse when a bus write updates a register
//  i2c_wr_idx   out  PTR_W           index written; valid with i2c_wr_pulse
//  busy         out  1               1 from matched address ACK until STOP or re-START
// BEHAVIOUR
//  Reset: sda_oe=0, busy=0, i2c_wr_pulse=0, i2c_wr_idx=0, pointer=0, regs=RESET_VAL, state IDLE.
//  Inputs are synchronised, then edge-detected on synchronised values. Add SYNC_STAGES+1 clk
//  of latency from pad to event.
//  START: SDA falling while SCL high. STOP: SDA rising while SCL high. Both act in every
//  state. START -> ADDR, bit count 0. STOP -> IDLE, sda_oe=0, busy=0.
//  Data is sampled on SCL rising edges, MSB first. sda_oe changes only on SCL falling edges.
//  States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, WAIT_STOP.
//  ADDR: after 8 bits, compare [7:1] with TARGET_ADDR. On mismatch go to WAIT_STOP and never
//    drive. On match, ACK: assert sda_oe on the next SCL fall and release it on the following
//    SCL fall. Set busy=1. R/W=0 -> PTR. R/W=1 -> RD, loading regs[pointer].
//  PTR: if byte < NUM_REGS, ACK, pointer=byte, then WR. If byte >= NUM_REGS, NACK (no drive),
//    pointer unchanged, then WAIT_STOP.
//  WR: after 8 bits, regs[pointer]=byte and pulse i2c_wr_pulse with i2c_wr_idx=pointer. ACK,
//    then pointer=(pointer+1) mod NUM_REGS. Return to WR for the next byte.
//  RD: drive sda_oe = ~bit on each SCL fall, MSB on the fall following the ACK.
//    RD_ACK: release SDA and sample the controller on SCL rise. ACK (0): pointer increments
//    with wrap, load the next register, go to RD. NACK (1): go to WAIT_STOP.
//  Repeated START mid-byte: abandon the partial byte. No register write happens.
//  Host write in the same cycle as a bus write to the same index: the bus write wins and the
//  host write is dropped. A host write to a different index is applied normally.
//  Reset mid-transaction: immediate return to the reset state. Because bus activity is
//  ignored until the next START, SDA is never held low after reset.
//  Pointer persists across transactions, so a write-PTR followed by a repeated-START read
//  works.
// STRUCTURE
//  i2c_pkg: state enum, I2C_ACK=1'b0, I2C_NACK=1'b1, I2C_RW_READ=1'b1.
//  Sub-module i2c_bus_sync: synchroniser plus scl_rise, scl_fall, start_det, stop_det pulses.
//  It is reusable by future I2C blocks.
//  Top: FSM, 4-bit bit counter, shift register, pointer, register array.
// TESTING
//  1. START, addr 0x2A+W, ptr 0x01, data 0xA5, STOP -> three ACKs, regs[1]=0xA5,
//     i2c_wr_pulse once with idx 1, busy drops after STOP.
//  2. Write ptr 0x03 with data 0x11,0x22 (NUM_REGS=4) -> regs[3]=0x11, regs[0]=0x22
//     (pointer wraps).
//  3. Write ptr 0x00, repeated START, 0x2A+R, read 2 bytes, controller ACK then NACK
//     -> bytes regs[0],regs[1]; SDA released after NACK.
//  4. Address 0x2B -> no ACK (sda_oe stays 0 for the whole frame), regs unchanged, busy=0.
//  5. Pointer byte 0x07 (NUM_REGS=4) -> NACK; a following data byte is ignored.
//  6. Reset asserted while driving a read bit 0 -> sda_oe=0 next cycle, regs=RESET_VAL;
//     the next transaction succeeds.

Source files
------------

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C target state encodings and bus constants
package i2c_pkg;

    typedef logic [3:0] i2c_state_t;

    localparam i2c_state_t ST_IDLE      = 4'd0;
    localparam i2c_state_t ST_ADDR      = 4'd1;
    localparam i2c_state_t ST_ADDR_ACK  = 4'd2;
    localparam i2c_state_t ST_PTR       = 4'd3;
    localparam i2c_state_t ST_PTR_ACK   = 4'd4;
    localparam i2c_state_t ST_WR        = 4'd5;
    localparam i2c_state_t ST_WR_ACK    = 4'd6;
    localparam i2c_state_t ST_RD        = 4'd7;
    localparam i2c_state_t ST_RD_ACK    = 4'd8;
    localparam i2c_state_t ST_WAIT_STOP = 4'd9;

    localparam logic I2C_ACK     = 1'b0;
    localparam logic I2C_NACK    = 1'b1;
    localparam logic I2C_RW_READ = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - SCL/SDA synchroniser with edge and START/STOP pulses
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_level
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic scl_prev_q, scl_prev_d;
    logic sda_prev_q, sda_prev_d;
    logic scl_rise_q, scl_rise_d;
    logic scl_fall_q, scl_fall_d;
    logic start_q, start_d;
    logic stop_q, stop_d;
    logic scl_now, sda_now;

    assign scl_now   = scl_sync_q[SYNC_STAGES-1];
    assign sda_now   = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_rise_q;
    assign scl_fall  = scl_fall_q;
    assign start_det = start_q;
    assign stop_det  = stop_q;
    assign sda_level = sda_now;

    // Shift pads through the chains and register one-cycle event pulses
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        scl_prev_d = scl_now;
        sda_prev_d = sda_now;
        scl_rise_d = scl_now & ~scl_prev_q;
        scl_fall_d = ~scl_now & scl_prev_q;
        start_d    = scl_now & scl_prev_q & sda_prev_q & ~sda_now;
        stop_d     = scl_now & scl_prev_q & ~sda_prev_q & sda_now;
    end

    // Lines reset to the idle-high bus level so reset itself creates no events
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
            scl_rise_q <= scl_rise_d;
            scl_fall_q <= scl_fall_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
        end
    end

endmodule

// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - I2C target protocol engine with pointer-addressed register file
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h2A,
    parameter int         NUM_REGS    = 4,
    parameter logic [7:0] RESET_VAL   = 8'h00,
    parameter int         SYNC_STAGES = 2,
    localparam int        PTR_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    input  logic                  host_wr_en,
    input  logic [PTR_W-1:0]      host_wr_idx,
    input  logic [7:0]            host_wr_data,
    output logic [8*NUM_REGS-1:0] regs_flat,
    output logic                  i2c_wr_pulse,
    output logic [PTR_W-1:0]      i2c_wr_idx,
    output logic                  busy
);

    localparam logic [7:0]       REG_LIMIT = 8'(NUM_REGS);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_REGS - 1);

    logic scl_rise, scl_fall, start_det, stop_det, sda_level;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_level (sda_level)
    );

    i2c_state_t       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       tx_q, tx_d;
    logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc;
    logic             rw_q, rw_d;
    logic             sda_oe_q, sda_oe_d;
    logic             busy_q, busy_d;
    logic             wr_pulse_q, wr_pulse_d;
    logic [PTR_W-1:0] wr_idx_q, wr_idx_d;
    logic [7:0]       regs_q [NUM_REGS];
    logic [7:0]       regs_d [NUM_REGS];

    assign sda_oe       = sda_oe_q;
    assign busy         = busy_q;
    assign i2c_wr_pulse = wr_pulse_q;
    assign i2c_wr_idx   = wr_idx_q;
    assign ptr_inc      = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[8*g +: 8] = regs_q[g];
    end

    // Protocol FSM: bits sampled on SCL rise, SDA drive changes only on SCL fall
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        ptr_d      = ptr_q;
        rw_d       = rw_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        wr_pulse_d = 1'b0;
        wr_idx_d   = wr_idx_q;
        for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];

        // Host write goes first so a same-index bus write below overrides it
        if (host_wr_en && (8'(host_wr_idx) < REG_LIMIT)) regs_d[host_wr_idx] = host_wr_data;

        if (start_det) begin
            state_d  = ST_ADDR;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (stop_det) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            if (scl_rise && (cnt_q < 4'd8) &&
                (state_q == ST_ADDR || state_q == ST_PTR || state_q == ST_WR || state_q == ST_RD)) begin
                shift_d = {shift_q[6:0], sda_level};
                cnt_d   = cnt_q + 4'd1;
            end
            case (state_q)
                ST_ADDR: if (scl_fall && cnt_q == 4'd8) begin
                    cnt_d = '0;
                    if (shift_q[7:1] == TARGET_ADDR) begin
                        sda_oe_d = 1'b1;
                        busy_d   = 1'b1;
                        rw_d     = shift_q[0];
                        tx_d     = regs_q[ptr_q];
                        state_d  = ST_ADDR_ACK;
                    end else begin
                        state_d  = ST_WAIT_STOP;
                    end
                end
                ST_ADDR_ACK: if (scl_fall) begin
                    cnt_d = '0;
                    if (rw_q == I2C_RW_READ) begin
                        sda_oe_d = ~tx_q[7];
                        state_d  = ST_RD;
                    end else begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_PTR;
                    end
                end
                ST_PTR: if (scl_fall && cnt_q == 4'd8) begin
                    cnt_d = '0;
                    if (shift_q < REG_LIMIT) begin
                        sda_oe_d = 1'b1;
                        ptr_d    = shift_q[PTR_W-1:0];
                        state_d  = ST_PTR_ACK;
                    end else begin
                        state_d  = ST_WAIT_STOP;
                    end
                end
                ST_PTR_ACK: if (scl_fall) begin
                    sda_oe_d = 1'b0;
                    state_d  = ST_WR;
                end
                ST_WR: if (scl_fall && cnt_q == 4'd8) begin
                    cnt_d          = '0;
                    regs_d[ptr_q]  = shift_q;
                    wr_pulse_d     = 1'b1;
                    wr_idx_d       = ptr_q;
                    sda_oe_d       = 1'b1;
                    state_d        = ST_WR_ACK;
                end
                ST_WR_ACK: if (scl_fall) begin
                    sda_oe_d = 1'b0;
                    ptr_d    = ptr_inc;
                    state_d  = ST_WR;
                end
                ST_RD: if (scl_fall) begin
                    if (cnt_q == 4'd8) begin
                        sda_oe_d = 1'b0;
                        cnt_d    = '0;
                        state_d  = ST_RD_ACK;
                    end else begin
                        sda_oe_d = ~tx_q[3'd7 - cnt_q[2:0]];
                    end
                end
                ST_RD_ACK: if (scl_rise) begin
                    if (sda_level == I2C_ACK) begin
                        ptr_d   = ptr_inc;
                        tx_d    = regs_q[ptr_inc];
                        state_d = ST_RD;
                    end else begin
                        state_d = ST_WAIT_STOP;
                    end
                end
                default: ;
            endcase
        end
    end

    // State, datapath and register file update
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            tx_q       <= '0;
            ptr_q      <= '0;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_idx_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            wr_pulse_q <= wr_pulse_d;
            wr_idx_q   <= wr_idx_d;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

endmodule
